// File: rtl/router_fsm_np.sv
// router_fsm_np: parametrised control FSM for a 1xNUM_PORTS packet router.
// The header address is latched at header time, so soft-reset and empty checks follow the
// packet's own port instead of live data_in_i. Out-of-range addresses go to a drop state.
//
// Optional feature macro: ROUTER_WAIT_TIMEOUT_EN. When defined, WAIT_TILL_EMPTY gives up after
// WAIT_TIMEOUT cycles, drops the packet, and pulses timeout_err_o.
//
// Ports:
//   clk_i            system clock, all state on the rising edge
//   resetn_i         synchronous active-low reset
//   pkt_valid_i      packet in progress from the source
//   data_in_i        header address field
//   fifo_full_i      full flag of the currently selected FIFO
//   fifo_empty_i     per-FIFO empty flags
//   soft_reset_i     per-FIFO timeout soft resets from the synchronizer
//   parity_done_i    parity byte captured by the register block
//   low_pkt_valid_i  pkt_valid fell while the FIFO was full
//   detect_add_o .. busy_o  state decodes towards the register/synchronizer blocks
//   drop_state_o     high while a bad packet is being discarded
//   dest_sel_o       one-hot latched destination, 0 when none
//   addr_err_o       one-cycle pulse on entry to the drop state for a bad address
//   timeout_err_o    one-cycle pulse on a wait timeout (ROUTER_WAIT_TIMEOUT_EN only)
module router_fsm_np #(
    parameter int unsigned NUM_PORTS    = 3,
    parameter int unsigned ADDR_W       = 2,
    parameter int unsigned WAIT_TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic                 pkt_valid_i,
    input  logic [ADDR_W-1:0]    data_in_i,
    input  logic                 fifo_full_i,
    input  logic [NUM_PORTS-1:0] fifo_empty_i,
    input  logic [NUM_PORTS-1:0] soft_reset_i,
    input  logic                 parity_done_i,
    input  logic                 low_pkt_valid_i,
    output logic                 detect_add_o,
    output logic                 lfd_state_o,
    output logic                 ld_state_o,
    output logic                 laf_state_o,
    output logic                 full_state_o,
    output logic                 write_enb_reg_o,
    output logic                 rst_int_reg_o,
    output logic                 busy_o,
    output logic                 drop_state_o,
    output logic [NUM_PORTS-1:0] dest_sel_o,
    output logic                 addr_err_o
`ifdef ROUTER_WAIT_TIMEOUT_EN
    ,
    output logic                 timeout_err_o
`endif
);

    if (NUM_PORTS < 2 || NUM_PORTS > 16 || (1 << ADDR_W) < NUM_PORTS || WAIT_TIMEOUT < 2)
    begin : g_bad_param
        $error("router_fsm_np: illegal parameter combination");
    end

    typedef enum logic [3:0] {
        StDecodeAddress    = 4'd0,
        StLoadFirstData    = 4'd1,
        StLoadData         = 4'd2,
        StLoadParity       = 4'd3,
        StCheckParityError = 4'd4,
        StFifoFullState    = 4'd5,
        StLoadAfterFull    = 4'd6,
        StWaitTillEmpty    = 4'd7,
        StDropPacket       = 4'd8
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_PORTS-1:0] dest_q, dest_d;
    logic                 addr_err_q, addr_err_d;
    logic [NUM_PORTS-1:0] addr_oh;
    logic                 addr_valid, addr_empty, dest_empty, dest_srst;

`ifdef ROUTER_WAIT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(WAIT_TIMEOUT);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_err_q, timeout_err_d;
    logic            wait_expired;
    assign wait_expired = (cnt_q == CntW'(WAIT_TIMEOUT - 1));
`endif

    // Decode the live header address; an all-zero one-hot means out of range.
    always_comb begin
        addr_oh = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (32'(data_in_i) == i) addr_oh[i] = 1'b1;
        end
    end

    assign addr_valid = |addr_oh;
    assign addr_empty = |(fifo_empty_i & addr_oh);
    assign dest_empty = |(fifo_empty_i & dest_q);
    assign dest_srst  = |(soft_reset_i & dest_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StDecodeAddress: begin
                if (!pkt_valid_i)     state_d = StDecodeAddress;
                else if (!addr_valid) state_d = StDropPacket;
                else if (addr_empty)  state_d = StLoadFirstData;
                else                  state_d = StWaitTillEmpty;
            end
            StLoadFirstData: state_d = StLoadData;
            StLoadData: begin
                if (fifo_full_i)       state_d = StFifoFullState;
                else if (!pkt_valid_i) state_d = StLoadParity;
                else                   state_d = StLoadData;
            end
            StLoadParity:       state_d = StCheckParityError;
            StCheckParityError: state_d = fifo_full_i ? StFifoFullState : StDecodeAddress;
            StFifoFullState:    state_d = fifo_full_i ? StFifoFullState : StLoadAfterFull;
            StLoadAfterFull: begin
                if (parity_done_i)        state_d = StDecodeAddress;
                else if (low_pkt_valid_i) state_d = StLoadParity;
                else                      state_d = StLoadData;
            end
            StWaitTillEmpty: begin
                // An empty FIFO on the expiry cycle still wins over the timeout.
                if (dest_empty)   state_d = StLoadFirstData;
`ifdef ROUTER_WAIT_TIMEOUT_EN
                else if (wait_expired) state_d = StDropPacket;
`endif
                else              state_d = StWaitTillEmpty;
            end
            StDropPacket: state_d = pkt_valid_i ? StDropPacket : StDecodeAddress;
            default:      state_d = StDecodeAddress;
        endcase

        // Soft reset of the packet's own port aborts it; other ports are ignored.
        if (dest_srst && state_q != StDecodeAddress && state_q != StDropPacket) begin
            state_d = StDecodeAddress;
        end

        if (state_d == StDecodeAddress) begin
            dest_d = '0;
        end else if (state_q == StDecodeAddress && pkt_valid_i && addr_valid) begin
            dest_d = addr_oh;
        end else begin
            dest_d = dest_q;
        end

        addr_err_d = (state_q == StDecodeAddress) && (state_d == StDropPacket);
`ifdef ROUTER_WAIT_TIMEOUT_EN
        timeout_err_d = (state_q == StWaitTillEmpty) && (state_d == StDropPacket);
        cnt_d         = (state_q == StWaitTillEmpty) ? cnt_q + 1'b1 : '0;
`endif

        detect_add_o    = (state_q == StDecodeAddress);
        lfd_state_o     = (state_q == StLoadFirstData);
        ld_state_o      = (state_q == StLoadData);
        laf_state_o     = (state_q == StLoadAfterFull);
        full_state_o    = (state_q == StFifoFullState);
        rst_int_reg_o   = (state_q == StCheckParityError);
        drop_state_o    = (state_q == StDropPacket);
        write_enb_reg_o = state_q inside {StLoadData, StLoadParity, StLoadAfterFull};
        busy_o          = state_q inside {StLoadFirstData, StLoadParity, StFifoFullState,
                                          StLoadAfterFull, StWaitTillEmpty, StCheckParityError};
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q       <= StDecodeAddress;
            dest_q        <= '0;
            addr_err_q    <= 1'b0;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            dest_q        <= dest_d;
            addr_err_q    <= addr_err_d;
`ifdef ROUTER_WAIT_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign dest_sel_o = dest_q;
    assign addr_err_o = addr_err_q;
`ifdef ROUTER_WAIT_TIMEOUT_EN
    assign timeout_err_o = timeout_err_q;
`endif

endmodule

// File: tb/tb_router_fsm_np.sv
module tb_router_fsm_np;
    localparam int NP = 3;
    localparam int AW = 2;
    localparam int WT = 8;
`ifdef ROUTER_WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // Model phases, numbered only for this bench.
    localparam int PDEC = 0, PLFD = 1, PLD = 2, PLP = 3, PCPE = 4, PFFS = 5, PLAF = 6;
    localparam int PWAIT = 7, PDROP = 8;

    logic          clk = 1'b0;
    logic          resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
    logic [AW-1:0] data_in;
    logic [NP-1:0] fifo_empty, soft_reset;
    logic          detect_add, lfd_state, ld_state, laf_state, full_state;
    logic          write_enb_reg, rst_int_reg, busy, drop_state, addr_err;
    logic [NP-1:0] dest_sel;
`ifdef ROUTER_WAIT_TIMEOUT_EN
    logic          timeout_err;
`endif

    always #5 clk = ~clk;

    router_fsm_np #(.NUM_PORTS(NP), .ADDR_W(AW), .WAIT_TIMEOUT(WT)) dut (
        .clk_i          (clk),
        .resetn_i       (resetn),
        .pkt_valid_i    (pkt_valid),
        .data_in_i      (data_in),
        .fifo_full_i    (fifo_full),
        .fifo_empty_i   (fifo_empty),
        .soft_reset_i   (soft_reset),
        .parity_done_i  (parity_done),
        .low_pkt_valid_i(low_pkt_valid),
        .detect_add_o   (detect_add),
        .lfd_state_o    (lfd_state),
        .ld_state_o     (ld_state),
        .laf_state_o    (laf_state),
        .full_state_o   (full_state),
        .write_enb_reg_o(write_enb_reg),
        .rst_int_reg_o  (rst_int_reg),
        .busy_o         (busy),
        .drop_state_o   (drop_state),
        .dest_sel_o     (dest_sel),
        .addr_err_o     (addr_err)
`ifdef ROUTER_WAIT_TIMEOUT_EN
        ,
        .timeout_err_o  (timeout_err)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: packet phase, latched port (-1 = none), pending pulses, wait length.
    int m_ph = PDEC;
    int m_port = -1;
    bit m_ae = 1'b0;
    bit m_te = 1'b0;
    int m_wait = 0;

    task automatic model_next();
        int nx;
        int a;
        bit srst;
        a = int'(data_in);
        if (!resetn) begin
            m_ph = PDEC; m_port = -1; m_ae = 0; m_te = 0; m_wait = 0;
            return;
        end
        case (m_ph)
            PDEC:  nx = !pkt_valid ? PDEC : (a >= NP) ? PDROP : fifo_empty[a] ? PLFD : PWAIT;
            PLFD:  nx = PLD;
            PLD:   nx = fifo_full ? PFFS : !pkt_valid ? PLP : PLD;
            PLP:   nx = PCPE;
            PCPE:  nx = fifo_full ? PFFS : PDEC;
            PFFS:  nx = fifo_full ? PFFS : PLAF;
            PLAF:  nx = parity_done ? PDEC : low_pkt_valid ? PLP : PLD;
            PWAIT: nx = fifo_empty[m_port] ? PLFD : (TO_EN && m_wait == WT) ? PDROP : PWAIT;
            default: nx = pkt_valid ? PDROP : PDEC;
        endcase
        srst = (m_port >= 0) && soft_reset[m_port];
        if (srst && m_ph != PDEC && m_ph != PDROP) nx = PDEC;
        m_ae = (m_ph == PDEC) && (nx == PDROP);
        m_te = (m_ph == PWAIT) && (nx == PDROP);
        if (nx == PDEC) m_port = -1;
        else if (m_ph == PDEC && pkt_valid && a < NP) m_port = a;
        m_wait = (nx == PWAIT) ? ((m_ph == PWAIT) ? m_wait + 1 : 1) : 0;
        m_ph = nx;
    endtask

    task automatic compare_all();
        logic [NP-1:0] exp_sel;
        exp_sel = '0;
        if (m_port >= 0) exp_sel[m_port] = 1'b1;
        check_eq("detect_add", 32'(detect_add), 32'(m_ph == PDEC));
        check_eq("lfd_state", 32'(lfd_state), 32'(m_ph == PLFD));
        check_eq("ld_state", 32'(ld_state), 32'(m_ph == PLD));
        check_eq("laf_state", 32'(laf_state), 32'(m_ph == PLAF));
        check_eq("full_state", 32'(full_state), 32'(m_ph == PFFS));
        check_eq("rst_int_reg", 32'(rst_int_reg), 32'(m_ph == PCPE));
        check_eq("drop_state", 32'(drop_state), 32'(m_ph == PDROP));
        check_eq("write_enb_reg", 32'(write_enb_reg), 32'(m_ph inside {PLD, PLP, PLAF}));
        check_eq("busy", 32'(busy), 32'(m_ph inside {PLFD, PLP, PCPE, PFFS, PLAF, PWAIT}));
        check_eq("dest_sel", 32'(dest_sel), 32'(exp_sel));
        check_eq("addr_err", 32'(addr_err), 32'(m_ae));
`ifdef ROUTER_WAIT_TIMEOUT_EN
        check_eq("timeout_err", 32'(timeout_err), 32'(m_te));
`endif
    endtask

    // Inputs are set at the falling edge; advance one clock and compare at the next fall.
    task automatic tick();
        model_next();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        resetn = 0; pkt_valid = 0; data_in = '0; fifo_full = 0; fifo_empty = '1;
        soft_reset = '0; parity_done = 0; low_pkt_valid = 0;
        @(negedge clk);
        tick();
        check_eq("rst_detect_add", 32'(detect_add), 32'd1);
        check_eq("rst_dest_sel", 32'(dest_sel), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        resetn = 1;

        // Clean packet to port 1.
        data_in = 2'd1; fifo_empty = 3'b111; pkt_valid = 1;
        tick();
        check_eq("hdr_lfd_latency", 32'(lfd_state), 32'd1);
        check_eq("hdr_dest_sel", 32'(dest_sel), 32'b010);
        data_in = 2'd3;
        repeat (3) tick();
        pkt_valid = 0;
        repeat (3) tick();
        check_eq("pkt1_back_decode", 32'(detect_add), 32'd1);

        // Out-of-range address.
        data_in = 2'd3; pkt_valid = 1;
        tick();
        check_eq("drop_addr_err", 32'(addr_err), 32'd1);
        check_eq("drop_busy", 32'(busy), 32'd0);
        check_eq("drop_wen", 32'(write_enb_reg), 32'd0);
        tick();
        check_eq("drop_addr_err_once", 32'(addr_err), 32'd0);
        check_eq("drop_hold", 32'(drop_state), 32'd1);
        pkt_valid = 0;
        tick();
        check_eq("drop_exit", 32'(detect_add), 32'd1);

        // Wait for port 2 with a foreign soft reset mid-wait.
        data_in = 2'd2; fifo_empty = 3'b011; pkt_valid = 1;
        tick();
        repeat (2) tick();
        soft_reset = 3'b001;
        tick();
        soft_reset = '0;
        tick();
        check_eq("wait_ignore_srst", 32'(dest_sel), 32'b100);
        fifo_empty = 3'b111;
        tick();
        check_eq("wait_to_lfd", 32'(lfd_state), 32'd1);
        tick();
        // Full while loading, then recover via low_pkt_valid.
        fifo_full = 1; pkt_valid = 0;
        repeat (3) tick();
        check_eq("ffs_wen", 32'(write_enb_reg), 32'd0);
        fifo_full = 0; low_pkt_valid = 1;
        repeat (3) tick();
        low_pkt_valid = 0;
        tick();

        // Own-port soft reset in LD, then reset during FFS.
        data_in = 2'd1; pkt_valid = 1;
        repeat (2) tick();
        soft_reset = 3'b010;
        tick();
        soft_reset = '0;
        check_eq("srst_own_port", 32'(dest_sel), 32'd0);
        repeat (3) tick();
        fifo_full = 1;
        tick();
        resetn = 0;
        tick();
        check_eq("rst_in_ffs", 32'(detect_add), 32'd1);
        resetn = 1; fifo_full = 0; pkt_valid = 0;
        tick();

`ifdef ROUTER_WAIT_TIMEOUT_EN
        begin
            int n;
            bit seen;
            data_in = 2'd2; fifo_empty = '0; pkt_valid = 1;
            tick();
            n = 0; seen = 0;
            while (!seen && n < 20) begin
                tick();
                n++;
                seen = drop_state;
            end
            check_eq("timeout_wait_len", 32'(n), 32'd8);
            check_eq("timeout_err_pulse", 32'(timeout_err), 32'd1);
            check_eq("timeout_no_addr_err", 32'(addr_err), 32'd0);
            pkt_valid = 0; fifo_empty = '1;
            tick();
        end
`endif

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            resetn        = ($urandom_range(63) != 0);
            pkt_valid     = ($urandom_range(3) != 0);
            data_in       = AW'($urandom_range(3));
            fifo_full     = ($urandom_range(3) == 0);
            fifo_empty    = NP'($urandom);
            soft_reset    = ($urandom_range(15) == 0) ? NP'($urandom) : '0;
            parity_done   = ($urandom_range(3) == 0);
            low_pkt_valid = ($urandom_range(3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
- Parametrised successor to the 1x3 router control FSM; drives the same load/parity/full handshakes towards the register and synchronizer blocks.
- Supports NUM_PORTS output FIFOs.
- Latches the destination at header time, so soft reset and empty checks track the packet's port, not live data_in.
- Adds a DROP_PACKET path for out-of-range addresses.

Parameters:
- NUM_PORTS, 3, number of output FIFOs/channels (2..16).
- ADDR_W, 2, width of header address field; must satisfy 2**ADDR_W >= NUM_PORTS.
- WAIT_TIMEOUT, 1024, cycles allowed in WAIT_TILL_EMPTY; used only with ROUTER_WAIT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  synchronous active-low reset.
- pkt_valid  in  1  packet in progress from source.
- data_in  in  ADDR_W  header address bits (data_in[ADDR_W-1:0] of header byte).
- fifo_full  in  1  full flag of currently selected FIFO.
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags.
- soft_reset  in  NUM_PORTS  per-FIFO timeout soft resets from synchronizer.
- parity_done  in  1  parity byte captured by register block.
- low_pkt_valid  in  1  pkt_valid fell while FIFO was full.
- detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy  out  1 each  state decodes, same meaning as existing router.
- drop_state  out  1  high in DROP_PACKET.
- dest_sel  out  NUM_PORTS  one-hot latched destination; 0 when none.
- addr_err  out  1  registered one-cycle pulse on entry to DROP_PACKET.
- timeout_err  out  1  present only with ROUTER_WAIT_TIMEOUT_EN.

Behaviour:
- Reset values: state DECODE_ADDRESS, so detect_add=1. All other outputs 0, dest_q=0.
- State register update priority: !resetn > soft reset > next_state.
- Soft reset: soft_reset[dest_q]=1 in any state other than DECODE_ADDRESS/DROP_PACKET forces DECODE_ADDRESS next cycle and clears dest_q. Soft reset of a non-selected port is ignored.
- Address handling:
  - addr = data_in sampled in DECODE_ADDRESS.
  - valid when addr < NUM_PORTS.
  - dest_q loads onehot(addr) when pkt_valid && valid in DECODE_ADDRESS.
  - dest_q clears on return to DECODE_ADDRESS.
- Transitions:
  - DECODE_ADDRESS: !pkt_valid -> stay; invalid addr -> DROP_PACKET; fifo_empty[addr] -> LOAD_FIRST_DATA; else -> WAIT_TILL_EMPTY.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
  - LOAD_PARITY -> CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else -> LOAD_DATA.
  - WAIT_TILL_EMPTY: fifo_empty[dest_q] -> LOAD_FIRST_DATA; else stay.
  - DROP_PACKET: !pkt_valid -> DECODE_ADDRESS; else stay. The trailing parity byte arrives in DECODE_ADDRESS with pkt_valid=0 and is ignored.
- Output decodes (Moore, combinational from state):
  - busy = LFD|LP|FFS|LAF|WAIT|CPE; 0 in DROP_PACKET so the source streams the bad packet out.
  - write_enb_reg = LD|LP|LAF; never in DROP_PACKET.
  - rst_int_reg = CPE.
  - dest_sel = dest_q.
- State encoding: 4 bits, 9 states. Any unused encoding -> DECODE_ADDRESS next cycle.
- Latency: header-to-lfd_state is 1 cycle when the FIFO is empty.

Optional Feature:
- ROUTER_WAIT_TIMEOUT_EN defined:
  - Counter (clog2(WAIT_TIMEOUT) bits) clears on entry to WAIT_TILL_EMPTY and increments each cycle while there.
  - When the count reaches WAIT_TIMEOUT-1 with fifo_empty[dest_q]=0, the FSM goes to DROP_PACKET and timeout_err pulses for one cycle; addr_err stays 0.
  - fifo_empty[dest_q] on the same cycle as the timeout wins -> LOAD_FIRST_DATA.
- Not defined: no counter, no timeout_err port; WAIT_TILL_EMPTY waits indefinitely.

Test Plan:
- Reset, then header addr=1, fifo_empty=3'b111, pkt_valid 4 cycles, no full -> DECODE, LFD, LD x3, LP, CPE, DECODE; dest_sel=3'b010 throughout; busy high in LFD/LP/CPE.
- Header addr=2, fifo_empty[2]=0 for 5 cycles then 1 -> WAIT_TILL_EMPTY 5 cycles, then LFD; soft_reset[0] pulsed mid-wait has no effect.
- In LD, fifo_full=1 for 3 cycles with pkt_valid dropping -> FFS x3, LAF; low_pkt_valid=1, parity_done=0 -> LP, CPE; write_enb_reg=0 in FFS.
- NUM_PORTS=3, header addr=3 -> DROP_PACKET, addr_err=1 for exactly one cycle, busy=0, write_enb_reg=0; pkt_valid low -> DECODE.
- Soft_reset[1] asserted in LD for port 1 -> DECODE next cycle, dest_sel=0; resetn low during FFS -> DECODE, all outputs at reset values.
- With ROUTER_WAIT_TIMEOUT_EN, WAIT_TIMEOUT=8, fifo_empty never set -> exactly 8 cycles in WAIT, then DROP with timeout_err pulse.
